ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 136 +++++++++++++
 tb/tb_ram_bist.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// Memory self-test: fills an inferred single-port RAM with a seeded pattern,
// reads it back with one-cycle latency and counts mismatching words.
//
//   state | meaning
//   IDLE  | waiting for start; last result held
//   WRITE | one pattern write per cycle, address ascending
//   READ  | one read per cycle, address ascending
//   DRAIN | compare of the final read word
//   DONE  | one-cycle done pulse, pass reflects the run
module ram_bist #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_50M,
    input  logic              RST_N,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              inject_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   seed_q;
    logic                inj_q;
    logic                cmp_vld;
    logic                we;
    logic [DATA_W-1:0]   wdata;
    logic                mismatch;
    logic                cmp_ok;
    logic                accept;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] av;
        av = DATA_W'(a);
        case (m)
            2'd0:    pattern = av + s;
            2'd1:    pattern = s;
            2'd2:    pattern = a[0] ? ~s : s;
            default: pattern = ~(av + s);
        endcase
    endfunction

    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (abort) state_nxt = IDLE;
                     else if (&addr) state_nxt = READ;
            READ:    if (abort) state_nxt = IDLE;
                     else if (&addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = abort ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == WRITE) || (state == READ) || (state == DRAIN);
        done  = (state == DONE);
        we    = (state == WRITE);
        // Fault injection flips bit 0 of the stored word only; expectation is untouched.
        wdata = pattern(mode_q, seed_q, addr) ^ DATA_W'(inj_q && (addr == '0));
    end

    assign accept   = (state == IDLE) && start;
    assign mismatch = rd_data != pattern(mode_q, seed_q, rd_addr);
    assign cmp_ok   = cmp_vld && !abort;

    always_ff @(posedge clk_50M) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) rd_data <= '0;
        else        rd_data <= mem[addr];
    end

    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            addr           <= '0;
            mode_q         <= '0;
            seed_q         <= '0;
            inj_q          <= 1'b0;
            cmp_vld        <= 1'b0;
            rd_addr        <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else if (accept) begin
            addr           <= '0;
            mode_q         <= mode;
            seed_q         <= seed;
            inj_q          <= inject_err;
            cmp_vld        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            cmp_vld <= (state == READ) && !abort;
            if (state == READ) rd_addr <= addr;
            if ((state == WRITE) || (state == READ))
                addr <= abort ? '0 : addr + 1'b1;
            if (cmp_ok && mismatch) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) first_err_addr <= rd_addr;
            end
            if (busy && abort)
                pass <= 1'b0;
            else if (state == DRAIN)
                pass <= (err_cnt == '0) && !(cmp_ok && mismatch);
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: cycle-indexed run model with a persistent memory image,
// per-cycle output comparison and directed runs with literal expectations.
module tb_ram_bist;
    localparam int D = 32;

    logic       clk_50M = 1'b0;
    logic       RST_N = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] seed = '0;
    logic       inject_err = 1'b0;
    logic       busy, done, pass;
    logic [5:0] err_cnt;
    logic [4:0] first_err_addr, rd_addr;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    ram_bist #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .abort(abort),
        .mode(mode), .seed(seed), .inject_err(inject_err),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] s, input int a);
        logic [7:0] av;
        av = a[7:0];
        case (m)
            2'd0:    return av + s;
            2'd1:    return s;
            2'd2:    return (a % 2 == 0) ? s : ~s;
            default: return ~(av + s);
        endcase
    endfunction

    // Model: m_k is the cycle index since the accepted start (0 = idle).
    // Cycles 1..D write address k-1, D+1..2D read, compares land in D+2..2D+1,
    // 2D+2 is the done cycle.
    int         m_k = 0;
    logic [1:0] m_mode = '0;
    logic [7:0] m_seed = '0;
    bit         m_inj = 1'b0;
    bit         m_pass = 1'b0;
    int         m_err = 0;
    int         m_fea = 0;
    int         m_a;
    logic [7:0] mem_m [D];

    always @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            m_k = 0; m_pass = 0; m_err = 0; m_fea = 0;
            m_mode = '0; m_seed = '0; m_inj = 0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k = 1; m_mode = mode; m_seed = seed; m_inj = inject_err;
                m_err = 0; m_fea = 0; m_pass = 0;
            end
        end else begin
            if (m_k <= D)
                mem_m[m_k-1] = pat(m_mode, m_seed, m_k-1) ^ ((m_inj && m_k == 1) ? 8'h01 : 8'h00);
            if (m_k >= D+2 && m_k <= 2*D+1 && !abort) begin
                m_a = m_k - D - 2;
                if (mem_m[m_a] != pat(m_mode, m_seed, m_a)) begin
                    if (m_err == 0) m_fea = m_a;
                    if (m_err < D) m_err++;
                end
            end
            if (m_k <= 2*D+1 && abort) begin
                m_k = 0; m_pass = 0;
            end else if (m_k == 2*D+1) begin
                m_pass = (m_err == 0); m_k++;
            end else if (m_k == 2*D+2) begin
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    logic [7:0] cap [D];
    int c_a;

    always @(negedge clk_50M) begin
        if (chk_en) begin
            chk("busy", busy, (m_k >= 1 && m_k <= 2*D+1));
            chk("done", done, (m_k == 2*D+2));
            chk("pass", pass, m_pass);
            chk("err_cnt", err_cnt, m_err);
            chk("first_err_addr", first_err_addr, m_fea);
            if (m_k >= D+2 && m_k <= 2*D+1) begin
                c_a = m_k - D - 2;
                chk("rd_addr", rd_addr, c_a);
                chk("rd_data", rd_data, mem_m[c_a]);
                cap[c_a] = rd_data;
            end
        end
    end

    int done_at, busy_n, done_n;

    task automatic run(input logic [1:0] m, input logic [7:0] s, input bit inj,
                       input int start_again_at, input int abort_at);
        @(negedge clk_50M);
        mode = m; seed = s; inject_err = inj; start = 1'b1; abort = (abort_at == 0);
        @(negedge clk_50M);
        start = 1'b0; abort = 1'b0;
        done_at = -1; busy_n = 0; done_n = 0;
        for (int c = 1; c <= 80; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            start = (c == start_again_at);
            abort = (c == abort_at);
            @(negedge clk_50M);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #2 RST_N = 1'b0;
        repeat (2) @(negedge clk_50M);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        RST_N = 1'b1;
        chk_en = 1'b1;

        run(2'd0, 8'h00, 1'b0, -1, -1);
        chk("m0_done_at", done_at, 66);
        chk("m0_busy_cycles", busy_n, 65);
        chk("m0_done_count", done_n, 1);
        chk("m0_pass", pass, 1);
        chk("m0_err_cnt", err_cnt, 0);
        chk("m0_rd0", cap[0], 8'h00);
        chk("m0_rd17", cap[17], 8'h11);
        chk("m0_rd31", cap[31], 8'h1F);

        run(2'd1, 8'hA5, 1'b1, -1, -1);
        chk("inj_done_count", done_n, 1);
        chk("inj_pass", pass, 0);
        chk("inj_err_cnt", err_cnt, 1);
        chk("inj_first_err_addr", first_err_addr, 0);
        chk("inj_rd0", cap[0], 8'hA4);
        chk("inj_rd1", cap[1], 8'hA5);

        run(2'd2, 8'h0F, 1'b0, -1, -1);
        chk("m2_rd0", cap[0], 8'h0F);
        chk("m2_rd1", cap[1], 8'hF0);
        chk("m2_rd30", cap[30], 8'h0F);
        chk("m2_pass", pass, 1);

        run(2'd3, 8'hF0, 1'b0, -1, -1);
        chk("m3_rd31", cap[31], 8'hF0);
        chk("m3_rd0", cap[0], 8'h0F);
        chk("m3_pass", pass, 1);

        run(2'd0, 8'h3C, 1'b0, 10, -1);
        chk("restart_done_count", done_n, 1);
        chk("restart_done_at", done_at, 66);
        chk("restart_pass", pass, 1);

        run(2'd1, 8'h55, 1'b1, -1, 40);
        chk("abort_done_count", done_n, 0);
        chk("abort_busy_cycles", busy_n, 40);
        chk("abort_pass", pass, 0);
        chk("abort_err_cnt", err_cnt, 1);
        chk("abort_first_err_addr", first_err_addr, 0);

        run(2'd1, 8'h55, 1'b0, -1, -1);
        chk("post_abort_pass", pass, 1);
        chk("post_abort_done_at", done_at, 66);

        run(2'd0, 8'h77, 1'b0, -1, 0);
        chk("abort_with_start_done_count", done_n, 1);
        chk("abort_with_start_pass", pass, 1);

        // Reset in the middle of the write phase (address 12).
        @(negedge clk_50M);
        mode = 2'd0; seed = 8'h00; inject_err = 1'b0; start = 1'b1;
        @(negedge clk_50M);
        start = 1'b0;
        repeat (12) @(negedge clk_50M);
        chk("pre_rst_busy", busy, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_first_err_addr", first_err_addr, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        chk("midrst_rd_data", rd_data, 0);
        repeat (2) @(negedge clk_50M);
        RST_N = 1'b1;

        run(2'd0, 8'h00, 1'b0, -1, -1);
        chk("post_rst_done_at", done_at, 66);
        chk("post_rst_done_count", done_n, 1);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_rd31", cap[31], 8'h1F);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
